// File: rtl/dot_int_acc.sv
// dot_int_acc: streaming k-way integer dot product with multi-beat accumulation and valid/ready flow control
module dot_int_acc #(
  parameter int bit_width = 8,
  parameter int k = 32,
  parameter int max_beats = 16,
  parameter int p_width = 2*bit_width + 2 + $clog2(k),
  parameter int acc_width = p_width + $clog2(max_beats),
  parameter int cnt_width = $clog2(max_beats) + 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  output logic o_ready,
  input  logic i_last,
  input  logic i_signed,
  input  logic [bit_width-1:0] i_op0 [k],
  input  logic [bit_width-1:0] i_op1 [k],
  output logic o_valid,
  input  logic i_ready,
  output logic signed [acc_width-1:0] o_dp,
  output logic [cnt_width-1:0] o_beats,
  output logic o_ovf
);
  localparam logic [cnt_width-1:0] full = cnt_width'(max_beats);
  logic en, v1, l1, s1, v2, l2, ovf;
  logic [bit_width-1:0] a1 [k];
  logic [bit_width-1:0] b1 [k];
  logic signed [2*bit_width+1:0] prod [k];
  logic signed [p_width-1:0] psum, p2;
  logic signed [acc_width-1:0] acc, sum;
  logic [cnt_width-1:0] cnt, cnt_inc;
  assign en = i_rst_n && (!o_valid || i_ready);
  assign o_ready = en;
  for (genvar i = 0; i < k; i++) begin : g_mul
    logic signed [2*bit_width+1:0] ea, eb;
    assign ea = {{(bit_width+2){s1 & a1[i][bit_width-1]}}, a1[i]};
    assign eb = {{(bit_width+2){s1 & b1[i][bit_width-1]}}, b1[i]};
    assign prod[i] = ea * eb;
  end
  always_comb begin
    psum = '0;
    for (int i = 0; i < k; i++) psum = psum + p_width'(prod[i]);
  end
  assign sum = acc + acc_width'(p2);
  assign cnt_inc = (cnt == full) ? full : cnt + cnt_width'(1);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      {v1, v2, ovf, o_valid, o_ovf} <= '0;
      acc <= '0;
      cnt <= '0;
      o_dp <= '0;
      o_beats <= '0;
    end else if (en) begin
      v1 <= i_valid;
      v2 <= v1;
      if (v2 && l2) begin
        o_dp <= sum;
        o_beats <= cnt_inc;
        o_ovf <= ovf || cnt == full;
        o_valid <= 1'b1;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        o_valid <= 1'b0;
        if (v2) begin
          acc <= sum;
          cnt <= cnt_inc;
          ovf <= ovf || cnt == full;
        end
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (en) begin
      a1 <= i_op0;
      b1 <= i_op1;
      l1 <= i_last;
      s1 <= i_signed;
      l2 <= l1;
      p2 <= psum;
    end
  end
endmodule
